// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word-addressed imem requests and feeds the F/D
// latch, with branch redirect/squash and a 1-entry skid buffer that absorbs decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [31:0] NOP_INSN    = 32'd0,
  parameter int unsigned IMEM_ADDR_W = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   ctrl_branch,
  input  logic [31:0]            PCafterJump,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] address_imem,
  input  logic                   imem_ready,
  input  logic [31:0]            q_imem,
  output logic [31:0]            fd_insn,
  output logic [31:0]            fd_PC,
  output logic                   fd_valid
);

  typedef enum logic [1:0] {StRun, StStall, StDrain, StRedirect} mode_e;

  logic [31:0] pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic        skid_full;
  logic [31:0] skid_insn;
  logic [31:0] skid_pc;
  logic        accept;
  mode_e       mode;
  logic        unused_pc_hi;

  // Never request while a stalled response would have nowhere to go but a full skid.
  always_comb begin
    imem_req = reset && !ctrl_branch && !skid_full && !(stall && inflight);
    accept   = imem_req && imem_ready;
    if (ctrl_branch) begin
      mode = StRedirect;
    end else if (stall) begin
      mode = StStall;
    end else if (skid_full) begin
      mode = StDrain;
    end else begin
      mode = StRun;
    end
  end

  assign address_imem = pc[IMEM_ADDR_W-1:0];
  assign unused_pc_hi = ^pc[31:IMEM_ADDR_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'd0;
      skid_full   <= 1'b0;
      skid_insn   <= 32'd0;
      skid_pc     <= 32'd0;
      fd_insn     <= NOP_INSN;
      fd_PC       <= 32'd0;
      fd_valid    <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_pc <= pc;
      end
      unique case (mode)
        StRedirect: begin
          pc        <= PCafterJump;
          skid_full <= 1'b0;
          fd_insn   <= NOP_INSN;
          fd_valid  <= 1'b0;
        end
        StStall: begin
          if (accept) begin
            pc <= pc + 32'd1;
          end
          if (inflight) begin
            skid_full <= 1'b1;
            skid_insn <= q_imem;
            skid_pc   <= inflight_pc + 32'd1;
          end
        end
        StDrain: begin
          fd_insn   <= skid_insn;
          fd_PC     <= skid_pc;
          fd_valid  <= 1'b1;
          skid_full <= 1'b0;
        end
        StRun: begin
          if (accept) begin
            pc <= pc + 32'd1;
          end
          if (inflight) begin
            fd_insn  <= q_imem;
            fd_PC    <= inflight_pc + 32'd1;
            fd_valid <= 1'b1;
          end else begin
            fd_insn  <= NOP_INSN;
            fd_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus hand-written corner sequences.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hDEAD_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        ctrl_branch;
  logic [31:0] PCafterJump;
  logic        imem_req;
  logic [11:0] address_imem;
  logic        imem_ready;
  logic [31:0] q_imem = 32'd0;
  logic [31:0] fd_insn;
  logic [31:0] fd_PC;
  logic        fd_valid;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(
    .RESET_PC    (32'd0),
    .NOP_INSN    (NOP),
    .IMEM_ADDR_W (12)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .ctrl_branch  (ctrl_branch),
    .PCafterJump  (PCafterJump),
    .imem_req     (imem_req),
    .address_imem (address_imem),
    .imem_ready   (imem_ready),
    .q_imem       (q_imem),
    .fd_insn      (fd_insn),
    .fd_PC        (fd_PC),
    .fd_valid     (fd_valid)
  );

  always #5 clock = ~clock;

  // Memory returns addr+100 one cycle after the address is presented.
  always @(posedge clock) q_imem <= {20'd0, address_imem} + 32'd100;

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] t;
    logic        r;
    logic        e_req;
    logic [11:0] e_addr;
    logic        e_fv;
    logic [31:0] e_fi;
    logic [31:0] e_fpc;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic r);
    stall = s; ctrl_branch = b; PCafterJump = t; imem_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_fd(input string name, input logic v, input logic [31:0] i,
                        input logic [31:0] p);
    chk({name, ".fd_valid"}, {31'd0, fd_valid}, {31'd0, v});
    chk({name, ".fd_insn"}, fd_insn, i);
    chk({name, ".fd_PC"}, fd_PC, p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          s  b  t    r  req addr fv fi            fpc
    vecs[0]  = '{0, 0, 0,  1, 1, 0,  0, NOP,          0};
    vecs[1]  = '{0, 0, 0,  1, 1, 1,  1, 100,          1};
    vecs[2]  = '{0, 0, 0,  1, 1, 2,  1, 101,          2};
    vecs[3]  = '{0, 0, 0,  1, 1, 3,  1, 102,          3};
    vecs[4]  = '{0, 0, 0,  1, 1, 4,  1, 103,          4};
    vecs[5]  = '{0, 0, 0,  1, 1, 5,  1, 104,          5};
    vecs[6]  = '{1, 0, 0,  1, 0, 6,  1, 104,          5};   // pc=5 word into skid
    vecs[7]  = '{1, 0, 0,  1, 0, 6,  1, 104,          5};
    vecs[8]  = '{1, 0, 0,  1, 0, 6,  1, 104,          5};
    vecs[9]  = '{0, 0, 0,  1, 0, 6,  1, 105,          6};   // drain
    vecs[10] = '{0, 0, 0,  1, 1, 6,  0, NOP,          6};
    vecs[11] = '{0, 0, 0,  1, 1, 7,  1, 106,          7};
    vecs[12] = '{0, 0, 0,  1, 1, 8,  1, 107,          8};
    vecs[13] = '{0, 1, 40, 1, 0, 9,  0, NOP,          8};   // redirect, 8's word dropped
    vecs[14] = '{0, 0, 0,  1, 1, 40, 0, NOP,          8};
    vecs[15] = '{0, 0, 0,  1, 1, 41, 1, 140,          41};
    vecs[16] = '{0, 0, 0,  1, 1, 42, 1, 141,          42};
    vecs[17] = '{0, 0, 0,  0, 1, 43, 1, 142,          43};  // memory not ready
    vecs[18] = '{0, 0, 0,  0, 1, 43, 0, NOP,          43};
    vecs[19] = '{0, 0, 0,  1, 1, 43, 0, NOP,          43};
    vecs[20] = '{0, 0, 0,  1, 1, 44, 1, 143,          44};

    reset = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    tick();
    chk("reset.imem_req", {31'd0, imem_req}, 32'd0);
    chk("reset.address", {20'd0, address_imem}, 32'd0);
    chk_fd("reset", 1'b0, NOP, 32'd0);

    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].s, vecs[i].b, vecs[i].t, vecs[i].r);
      chk($sformatf("v%0d.imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d.address", i), {20'd0, address_imem}, {20'd0, vecs[i].e_addr});
      tick();
      chk_fd($sformatf("v%0d", i), vecs[i].e_fv, vecs[i].e_fi, vecs[i].e_fpc);
      @(negedge clock);
    end

    // Redirect while stalled with a full skid: redirect wins, skid discarded.
    drive(1, 0, 0, 1);
    chk("skid.req", {31'd0, imem_req}, 32'd0);
    tick();
    chk_fd("skid.hold", 1'b1, 143, 44);
    @(negedge clock);
    drive(1, 1, 200, 1);
    chk("brst.req", {31'd0, imem_req}, 32'd0);
    tick();
    chk_fd("brst", 1'b0, NOP, 44);
    @(negedge clock);
    drive(0, 0, 0, 1);
    chk("brst.next_req", {31'd0, imem_req}, 32'd1);
    chk("brst.next_addr", {20'd0, address_imem}, 32'd200);
    tick();
    chk_fd("brst.nodrain", 1'b0, NOP, 44);
    @(negedge clock);
    drive(0, 0, 0, 1);
    tick();
    chk_fd("brst.target", 1'b1, 300, 201);
    @(negedge clock);

    // PC wrap at 32'hFFFFFFFF.
    drive(0, 1, 32'hFFFF_FFFF, 1);
    tick();
    @(negedge clock);
    drive(0, 0, 0, 1);
    chk("wrap.addr", {20'd0, address_imem}, 32'hFFF);
    tick();
    @(negedge clock);
    chk("wrap.addr0", {20'd0, address_imem}, 32'd0);
    tick();
    chk_fd("wrap", 1'b1, 32'hFFF + 100, 32'd0);

    // Asynchronous reset mid-cycle with a request in flight.
    #2;
    reset = 1'b0;
    #1;
    chk("areset.imem_req", {31'd0, imem_req}, 32'd0);
    chk_fd("areset", 1'b0, NOP, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(0, 0, 0, 1);
    chk("rel.addr", {20'd0, address_imem}, 32'd0);
    chk("rel.req", {31'd0, imem_req}, 32'd1);
    tick();
    chk_fd("rel.ignore", 1'b0, NOP, 32'd0);
    @(negedge clock);
    tick();
    chk_fd("rel.first", 1'b1, 100, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
